// File: rtl/neopixel_fb_ctrl.sv
// Neopixel frame buffer: arbitrated byte writes into a back buffer,
// tear-free publish to the front buffer on the sync window, sequenced clear.
module neopixel_fb_ctrl #(
  parameter int NUM_BYTES = 48,
  parameter int ADDR_W    = 6
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   a_valid,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [7:0]             a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [7:0]             b_data,
  output logic                   b_ready,
  input  logic                   commit,
  input  logic                   clear,
  input  logic                   vblank,
  output logic [8*NUM_BYTES-1:0] framebuf,
  output logic                   swap_done,
  output logic [7:0]             frame_cnt,
  output logic                   addr_err,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    PENDING
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BYTES - 1);

  state_t            state;
  logic [7:0]        back [NUM_BYTES];
  logic [ADDR_W-1:0] clr_idx;
  logic              commit_pend;
  logic              last_a;
  logic              vblank_q;

  logic              wr_en;
  logic              grant_a;
  logic              grant_b;
  logic              acc;
  logic              in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  // last_a low means B won last, so A takes the next tie
  always_comb begin
    wr_en    = (state == IDLE) && !clear;
    grant_a  = a_valid && (!b_valid || !last_a);
    grant_b  = b_valid && !grant_a;
    a_ready  = wr_en && grant_a;
    b_ready  = wr_en && grant_b;
    acc      = a_ready || b_ready;
    wr_addr  = grant_a ? a_addr : b_addr;
    wr_data  = grant_a ? a_data : b_data;
    in_range = int'(wr_addr) < NUM_BYTES;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      for (int k = 0; k < NUM_BYTES; k++)
        back[k] <= '0;
      framebuf    <= '0;
      frame_cnt   <= '0;
      swap_done   <= 1'b0;
      addr_err    <= 1'b0;
      commit_pend <= 1'b0;
      last_a      <= 1'b0;
      vblank_q    <= 1'b0;
      clr_idx     <= '0;
    end else begin
      swap_done <= 1'b0;
      addr_err  <= 1'b0;
      vblank_q  <= vblank;
      unique case (state)
        IDLE: begin
          if (acc) begin
            last_a <= grant_a;
            if (in_range)
              back[wr_addr] <= wr_data;
            else
              addr_err <= 1'b1;
          end
          if (clear) begin
            state       <= CLEAR;
            clr_idx     <= '0;
            commit_pend <= commit;
          end else if (commit) begin
            state <= PENDING;
          end
        end
        CLEAR: begin
          back[clr_idx] <= '0;
          clr_idx       <= clr_idx + ADDR_W'(1);
          if (clr_idx == LAST) begin
            state       <= (commit_pend || commit) ? PENDING : IDLE;
            commit_pend <= 1'b0;
          end else if (commit) begin
            commit_pend <= 1'b1;
          end
        end
        PENDING: begin
          if (vblank && !vblank_q) begin
            for (int k = 0; k < NUM_BYTES; k++)
              framebuf[8*k +: 8] <= back[k];
            frame_cnt <= frame_cnt + 8'd1;
            swap_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_fb_ctrl.sv
// Bench for neopixel_fb_ctrl: directed scenarios plus random traffic,
// checked every cycle against a byte-array reference model.
module tb_neopixel_fb_ctrl;

  localparam int NB = 48;

  logic         clk = 1'b0;
  logic         nrst;
  logic         a_valid, b_valid;
  logic [5:0]   a_addr, b_addr;
  logic [7:0]   a_data, b_data;
  logic         a_ready, b_ready;
  logic         commit, clear, vblank;
  logic [383:0] framebuf;
  logic         swap_done, addr_err, busy;
  logic [7:0]   frame_cnt;

  int checks = 0;
  int failures = 0;

  neopixel_fb_ctrl dut (
    .clk       (clk),
    .nrst      (nrst),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .commit    (commit),
    .clear     (clear),
    .vblank    (vblank),
    .framebuf  (framebuf),
    .swap_done (swap_done),
    .frame_cnt (frame_cnt),
    .addr_err  (addr_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // reference model: 0 idle, 1 clearing, 2 waiting for sync edge
  logic [7:0] m_back  [NB];
  logic [7:0] m_front [NB];
  int         m_mode;
  int         m_cidx;
  bit         m_pend;
  bit         m_last_was_a;
  bit         m_vq;
  int         m_cnt;
  bit         m_swap;
  bit         m_err;
  bit         m_valid = 0;

  task automatic chk(string nm, logic [383:0] act, logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [383:0] front_vec();
    logic [383:0] v;
    for (int k = 0; k < NB; k++) v[8*k +: 8] = m_front[k];
    return v;
  endfunction

  task automatic model_step(bit take_a, bit take_b);
    int ad;
    logic [7:0] dt;
    if (!nrst) begin
      for (int k = 0; k < NB; k++) begin
        m_back[k] = 8'h00;
        m_front[k] = 8'h00;
      end
      m_mode = 0; m_cidx = 0; m_pend = 0;
      m_last_was_a = 0; m_vq = 0; m_cnt = 0;
      m_swap = 0; m_err = 0; m_valid = 1;
      return;
    end
    m_swap = 0;
    m_err = 0;
    if (m_mode == 0) begin
      if (take_a || take_b) begin
        ad = take_a ? int'(a_addr) : int'(b_addr);
        dt = take_a ? a_data : b_data;
        m_last_was_a = take_a;
        if (ad < NB) m_back[ad] = dt;
        else m_err = 1;
      end
      if (clear) begin
        m_mode = 1; m_cidx = 0; m_pend = commit;
      end else if (commit) begin
        m_mode = 2;
      end
    end else if (m_mode == 1) begin
      m_back[m_cidx] = 8'h00;
      if (commit) m_pend = 1;
      if (m_cidx == NB - 1) begin
        m_mode = m_pend ? 2 : 0;
        m_pend = 0;
      end else begin
        m_cidx++;
      end
    end else begin
      if (vblank && !m_vq) begin
        for (int k = 0; k < NB; k++) m_front[k] = m_back[k];
        m_cnt = (m_cnt + 1) % 256;
        m_swap = 1;
        m_mode = 0;
      end
    end
    m_vq = vblank;
  endtask

  // one clock: readies checked before the edge, registered outputs after
  task automatic tick();
    bit open, take_a, take_b;
    #1;
    open = m_valid && (m_mode == 0) && !clear;
    take_a = 0;
    take_b = 0;
    if (a_valid && b_valid) begin
      if (m_last_was_a) take_b = open;
      else take_a = open;
    end else begin
      take_a = open && a_valid;
      take_b = open && b_valid;
    end
    if (nrst && m_valid) begin
      chk("a_ready", a_ready, take_a);
      chk("b_ready", b_ready, take_b);
    end
    @(posedge clk);
    model_step(take_a, take_b);
    @(negedge clk);
    if (m_valid) begin
      chk("framebuf", framebuf, front_vec());
      chk("frame_cnt", frame_cnt, m_cnt[7:0]);
      chk("swap_done", swap_done, m_swap);
      chk("addr_err", addr_err, m_err);
      chk("busy", busy, m_mode != 0);
    end
  endtask

  task automatic quiet();
    a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0;
    a_data = 0; b_data = 0; commit = 0; clear = 0;
  endtask

  task automatic do_reset();
    quiet();
    nrst = 0;
    tick();
    nrst = 1;
  endtask

  task automatic vedge();
    vblank = 0;
    tick();
    vblank = 1;
    tick();
  endtask

  task automatic a_write(int ad, int dt);
    a_valid = 1; a_addr = 6'(ad); a_data = 8'(dt);
    tick();
    a_valid = 0;
  endtask

  task automatic do_commit();
    commit = 1;
    tick();
    commit = 0;
  endtask

  initial begin
    logic [3:0] pat;
    quiet();
    vblank = 0;
    nrst = 0;
    @(negedge clk);
    do_reset();
    chk("reset_fb", framebuf, 384'h0);
    chk("reset_cnt", frame_cnt, 8'd0);
    chk("reset_busy", busy, 1'b0);

    // 1: basic publish
    a_write(0, 8'hAA);
    a_write(47, 8'h55);
    do_commit();
    vedge();
    chk("t1_byte0", framebuf[7:0], 8'hAA);
    chk("t1_byte47", framebuf[383:376], 8'h55);
    chk("t1_swap", swap_done, 1'b1);
    chk("t1_cnt", frame_cnt, 8'd1);
    vblank = 0;
    tick();
    chk("t1_swap_off", swap_done, 1'b0);

    // 2: round-robin under contention
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; b_valid = 1;
      a_addr = 6'(i + 1); a_data = 8'(8'h10 + i);
      b_addr = 6'(i + 1); b_data = 8'(8'h20 + i);
      #1;
      pat[i] = a_ready;
      chk("t2_b_excl", b_ready, !a_ready);
      tick();
    end
    quiet();
    chk("t2_grants", pat, 4'b0101);
    do_commit();
    vedge();
    chk("t2_bytes", framebuf[39:0], 40'h23_12_21_10_AA & 40'hFFFFFFFF00);

    // 3: out-of-range write
    b_valid = 1; b_addr = 6'd50; b_data = 8'h99;
    tick();
    quiet();
    chk("t3_err", addr_err, 1'b1);
    do_commit();
    vedge();
    chk("t3_bytes", framebuf[39:0], 40'h23_12_21_10_00);
    chk("t3_cnt", frame_cnt, 8'd2);

    // 4: clear + commit over a full buffer
    for (int k = 0; k < NB; k++) a_write(k, 8'hFF);
    vblank = 0;
    clear = 1; commit = 1;
    tick();
    quiet();
    a_valid = 1;
    for (int k = 0; k < NB; k++) tick();
    a_valid = 0;
    chk("t4_busy", busy, 1'b1);
    vblank = 1;
    tick();
    chk("t4_fb", framebuf, 384'h0);
    chk("t4_cnt", frame_cnt, 8'd3);

    // 5: commit with vblank already high
    a_write(5, 8'h77);
    do_commit();
    a_valid = 1; a_addr = 6'd6; a_data = 8'h66;
    tick();
    commit = 1;
    tick();
    commit = 0;
    tick();
    chk("t5_nochg", frame_cnt, 8'd3);
    vedge();
    a_valid = 0;
    chk("t5_cnt", frame_cnt, 8'd4);
    chk("t5_byte5", framebuf[47:40], 8'h77);
    chk("t5_byte6", framebuf[55:48], 8'h00);
    vedge();
    chk("t5_once", frame_cnt, 8'd4);

    // 6: reset while pending
    a_write(3, 8'h42);
    vblank = 0;
    do_commit();
    do_reset();
    chk("t6_fb", framebuf, 384'h0);
    chk("t6_cnt", frame_cnt, 8'd0);
    chk("t6_busy", busy, 1'b0);
    vedge();
    chk("t6_noswap", frame_cnt, 8'd0);
    chk("t6_noswap_pulse", swap_done, 1'b0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      a_valid = ($urandom_range(0, 2) != 0);
      b_valid = ($urandom_range(0, 2) != 0);
      a_addr = 6'($urandom_range(0, 55));
      b_addr = 6'($urandom_range(0, 55));
      a_data = 8'($urandom);
      b_data = 8'($urandom);
      commit = ($urandom_range(0, 24) == 0);
      clear = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 11) == 0) vblank = !vblank;
      nrst = ($urandom_range(0, 799) != 0);
      tick();
    end
    nrst = 1;
    quiet();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
